gpio_shiftout: RTL
==================

// Module: gpio_shiftout
// PURPOSE
//  Downstream consumer of the 16-bit Avalon PIO output port. Serialises the PIO value
//  to an external 74HC595-style shift-register chain (SCLK/SDATA/LATCH).
//  Sends a frame only when the value changes, plus one unconditional frame after reset.
//  Sits between the Qsys system output port and board header pins.
// PARAMETERS
//  DATA_W   16  bits per frame; width of gpio_in; >=1
//  CLK_DIV  4   clk cycles per SCLK half-period, also latch pulse width; >=1
//  MSB_FIRST 1  1: shift gpio_in[DATA_W-1] first; 0: shift bit 0 first
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  gpio_in      in   DATA_W  parallel value from PIO out_port, synchronous to clk
//  force_frame  in   1       1-cycle pulse: request a frame even if value unchanged
//  sr_sclk      out  1       serial clock; ext. register samples on rising edge
//  sr_sdata     out  1       serial data; stable across each sr_sclk rising edge
//  sr_latch     out  1       storage-register latch pulse; high CLK_DIV cycles
//  busy         out  1       high while a frame (SHIFT or LATCH) is in progress
//  frame_cnt    out  8       completed frames; wraps 255->0
// BEHAVIOUR
//  - Reset: sr_sclk=0, sr_sdata=0, sr_latch=0, busy=0, frame_cnt=0, last_sent=0,
//    state=IDLE, init_pend=1, force_pend=0. All outputs are registered; no comb paths.
//  - FSM states: IDLE, SHIFT, LATCH.
//  - IDLE: if init_pend | force_pend | force_frame | (gpio_in != last_sent), then at the
//    clock edge: shreg<=gpio_in, snap<=gpio_in, bit_cnt<=0, div_cnt<=0, ->SHIFT.
//    busy rises together with the entry into SHIFT, i.e. 1 cycle after detection.
//  - SHIFT: each bit lasts 2*CLK_DIV cycles. sr_sdata = current bit for the whole
//    period. sr_sclk=0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles.
//    After DATA_W bits, ->LATCH. SHIFT lasts exactly DATA_W*2*CLK_DIV cycles.
//  - LATCH: sr_sclk=0, sr_latch=1 for CLK_DIV cycles. On exit: last_sent<=snap,
//    frame_cnt<=frame_cnt+1 (mod 256), init_pend<=0, ->IDLE, busy=0.
//  - Frame length is DATA_W*2*CLK_DIV + CLK_DIV busy cycles, then >=1 IDLE cycle
//    between frames.
//  - gpio_in changes during SHIFT/LATCH: frame in flight is not altered (uses snap).
//    The difference is re-evaluated in the first IDLE cycle, so only the newest value
//    is sent. Intermediate values may be skipped.
//  - force_frame during SHIFT/LATCH: sets force_pend. It is cleared on the next IDLE->SHIFT.
//    Multiple pulses collapse into one frame.
//  - force_frame in IDLE while a change is also present: exactly one frame.
//  - sr_sdata returns to 0 in IDLE and LATCH.
//  - reset_n asserted mid-frame: all outputs return to reset values immediately
//    (async). After release, init_pend forces a complete fresh frame. A partial frame
//    is never latched because sr_latch was low.
//  - No back-pressure toward the PIO; the block never stalls the Avalon side.
// STRUCTURE
//  - Shared package gpio_shiftout_pkg: state encoding localparams (IDLE=2'd0,
//    SHIFT=2'd1, LATCH=2'd2) and the frame-length function DATA_W*2*CLK_DIV+CLK_DIV.
//  - One sub-module: gpio_shiftout_tick. It is a CLK_DIV phase counter producing
//    half_tick/bit_end strobes. It is held cleared in IDLE.
//  - Top holds the FSM, shreg, snap, last_sent, bit_cnt, pending flags and frame_cnt.
// TESTING
//  - Reset release, gpio_in=16'h0000, CLK_DIV=2 -> one init frame of 16 zeros;
//    busy high 66 cycles; frame_cnt=1; then idle.
//  - gpio_in 0->16'hA5C3 -> sdata bits 1010_0101_1100_0011 MSB-first on 16 rising
//    sr_sclk edges; one latch pulse of 2 cycles; frame_cnt +1.
//  - gpio_in stable at 16'hA5C3 for 500 cycles -> no sr_sclk edges;
//    force_frame pulse -> exactly one identical frame.
//  - Mid-frame change 16'h1234->16'hFFFF->16'h0F0F during SHIFT -> current frame
//    completes as 16'h1234; the next frame is 16'h0F0F; 16'hFFFF is never sent.
//  - reset_n low at bit 7 -> outputs zero asynchronously, no latch pulse;
//    after release, full frame of the current gpio_in.
//  - 256 forced frames -> frame_cnt wraps to 0; MSB_FIRST=0 variant sends bit0 first.

Source files
------------

// File: rtl/gpio_shiftout_pkg.sv
// rtl/gpio_shiftout_pkg.sv - shared state encoding and frame-length helper for gpio_shiftout
package gpio_shiftout_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // Busy cycles per frame: DATA_W bits of two half-periods, then the latch pulse.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clk_div);
        return data_w * 2 * clk_div + clk_div;
    endfunction

endpackage

// File: rtl/gpio_shiftout_tick.sv
// rtl/gpio_shiftout_tick.sv - CLK_DIV phase counter producing half-period and bit-end strobes
module gpio_shiftout_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic half_tick_o,
    output logic bit_end_o,
    output logic phase_nxt_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;

    assign half_tick_o = !clear_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_end_o   = half_tick_o && phase_q;
    // The top registers its serial outputs from next-state values, so it needs phase_d.
    assign phase_nxt_o = phase_d;

    always_comb begin
        div_d   = div_q + DIV_W'(1);
        phase_d = phase_q;
        if (clear_i) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (half_tick_o) begin
            div_d   = '0;
            phase_d = !phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/gpio_shiftout.sv
// rtl/gpio_shiftout.sv - serialises a parallel PIO value to a 74HC595-style chain on change
module gpio_shiftout
    import gpio_shiftout_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              force_frame,
    output logic              sr_sclk,
    output logic              sr_sdata,
    output logic              sr_latch,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, snap_q, snap_d, last_sent_q, last_sent_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              init_pend_q, init_pend_d, force_pend_q, force_pend_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              sclk_q, sclk_d, sdata_q, sdata_d, latch_q, latch_d, busy_q, busy_d;
    logic              half_tick, bit_end, phase_nxt, start;

    gpio_shiftout_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (state_q == ST_IDLE),
        .half_tick_o (half_tick),
        .bit_end_o   (bit_end),
        .phase_nxt_o (phase_nxt)
    );

    assign start = (state_q == ST_IDLE) &&
                   (init_pend_q || force_pend_q || force_frame || (gpio_in != last_sent_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            snap_q       <= '0;
            last_sent_q  <= '0;
            bit_cnt_q    <= '0;
            init_pend_q  <= 1'b1;
            force_pend_q <= 1'b0;
            frame_cnt_q  <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            snap_q       <= snap_d;
            last_sent_q  <= last_sent_d;
            bit_cnt_q    <= bit_cnt_d;
            init_pend_q  <= init_pend_d;
            force_pend_q <= force_pend_d;
            frame_cnt_q  <= frame_cnt_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_end && (bit_cnt_q == BIT_W'(DATA_W - 1))) state_d = ST_LATCH;
            ST_LATCH: if (half_tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: the in-flight frame only ever uses snap, never the live gpio_in.
    always_comb begin
        shreg_d      = shreg_q;
        snap_d       = snap_q;
        last_sent_d  = last_sent_q;
        bit_cnt_d    = bit_cnt_q;
        init_pend_d  = init_pend_q;
        frame_cnt_d  = frame_cnt_q;
        force_pend_d = force_pend_q || (force_frame && (state_q != ST_IDLE));
        if (start) begin
            shreg_d      = gpio_in;
            snap_d       = gpio_in;
            bit_cnt_d    = '0;
            force_pend_d = 1'b0;
        end else if ((state_q == ST_SHIFT) && bit_end) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end else if ((state_q == ST_LATCH) && half_tick) begin
            last_sent_d = snap_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            init_pend_d = 1'b0;
        end
    end

    always_comb begin
        sclk_d  = (state_d == ST_SHIFT) && phase_nxt;
        sdata_d = (state_d == ST_SHIFT) && (MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0]);
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
    end

    assign sr_sclk   = sclk_q;
    assign sr_sdata  = sdata_q;
    assign sr_latch  = latch_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
